// File: rtl/adder_share_ctrl.sv
// Shares one 32-bit adder between two requesters, round-robin.
// Wide (64-bit) ops take two adder passes with the carry held in a register.
module full_adder32 (
  input  logic [31:0] dina_i,
  input  logic [31:0] dinb_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  // Plain ripple-style add; synthesis picks the structure
  assign {cout_o, sum_o} = {1'b0, dina_i} + {1'b0, dinb_i} + {32'b0, cin_i};
endmodule

module adder_share_ctrl #(
  parameter int DW         = 32,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2*DW-1:0] req0_a,
  input  logic [2*DW-1:0] req0_b,
  input  logic          req0_sub,
  input  logic          req0_wide,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2*DW-1:0] req1_a,
  input  logic [2*DW-1:0] req1_b,
  input  logic          req1_sub,
  input  logic          req1_wide,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [2*DW-1:0] rsp_sum,
  output logic          rsp_cout,
  output logic          rsp_ovf
);
  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t state_q, state_d;

  logic [2*DW-1:0] a_q, b_q;
  logic            sub_q, wide_q, id_q, rr_q, carry_q;
  logic [2*DW-1:0] sum_q;
  logic            cout_q, ovf_q;

  logic            gnt0, gnt1, acc;
  logic [DW-1:0]   ad_a, ad_b, ad_s;
  logic            ad_c, ad_co, ad_ovf;

  // Round-robin grant: a lone valid wins, a tie goes to the pointer
  assign gnt0 = req0_valid & (~req1_valid | ~rr_q);
  assign gnt1 = req1_valid & (~req0_valid |  rr_q);
  assign acc  = req0_ready | req1_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (acc) state_d = LO;
      LO:   state_d = wide_q ? HI : RESP;
      HI:   state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshakes only open in IDLE, response only in RESP
  always_comb begin
    req0_ready = (state_q == IDLE) & gnt0;
    req1_ready = (state_q == IDLE) & gnt1;
    rsp_valid  = (state_q == RESP);
  end

  // Adder operand mux; idle adder sees zeros
  always_comb begin
    ad_a = '0;
    ad_b = '0;
    ad_c = 1'b0;
    if (state_q == LO) begin
      ad_a = a_q[DW-1:0];
      ad_b = b_q[DW-1:0] ^ {DW{sub_q}};
      ad_c = sub_q;
    end else if (state_q == HI) begin
      ad_a = a_q[2*DW-1:DW];
      ad_b = b_q[2*DW-1:DW] ^ {DW{sub_q}};
      ad_c = carry_q;
    end
  end

  full_adder32 u_add (
    .dina_i (ad_a),
    .dinb_i (ad_b),
    .cin_i  (ad_c),
    .sum_o  (ad_s),
    .cout_o (ad_co)
  );

  assign ad_ovf = (ad_a[DW-1] == ad_b[DW-1]) & (ad_s[DW-1] != ad_a[DW-1]);

  // Operand capture on accept and result capture per adder pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      wide_q  <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= FIRST_PRIO;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (acc) begin
          a_q    <= req1_ready ? req1_a    : req0_a;
          b_q    <= req1_ready ? req1_b    : req0_b;
          sub_q  <= req1_ready ? req1_sub  : req0_sub;
          wide_q <= req1_ready ? req1_wide : req0_wide;
          id_q   <= req1_ready;
          rr_q   <= ~req1_ready;
        end
        LO: begin
          sum_q   <= {{DW{1'b0}}, ad_s};
          carry_q <= ad_co;
          if (!wide_q) begin
            cout_q <= ad_co;
            ovf_q  <= ad_ovf;
          end
        end
        HI: begin
          sum_q[2*DW-1:DW] <= ad_s;
          cout_q           <= ad_co;
          ovf_q            <= ad_ovf;
        end
        default: ;
      endcase
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_ovf  = ovf_q;
endmodule
